// File: rtl/jam_param.sv
`timescale 1ns/1ps
// jam_param: exhaustive N x N job-assignment engine.
// Walks all N! worker->job permutations in lexicographic order. For each one it
// reads the cost table through the W/J port (one-cycle read latency) and adds
// up the total. It reports the minimum total and how many permutations reach it.
// Optional feature macro: JAM_BEST_PERM_EN. It adds the BestPerm output, which
// holds the lexicographically first optimal assignment.

module jam_param #(
  parameter int N   = 8,   // workers = jobs, 2..8
  parameter int CW  = 7,   // cost word width
  parameter int IW  = 3,   // worker/job index width, 2^IW >= N
  parameter int MCW = 16   // MatchCount width (saturating)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  output logic [IW-1:0]    W,
  output logic [IW-1:0]    J,
  input  logic [CW-1:0]    Cost,
  output logic             Busy,
  output logic             Valid,
  output logic [CW+IW-1:0] MinCost,
  output logic [MCW-1:0]   MatchCount
`ifdef JAM_BEST_PERM_EN
  ,
  output logic [N*IW-1:0]  BestPerm
`endif
);

  localparam int SW = CW + IW;  // N*(2^CW-1) always fits in SW bits for N <= 2^IW

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAST,
    S_NEXT,
    S_DONE
  } state_e;

  state_e         state_q;
  logic [IW-1:0]  perm_q [N];
  logic [IW-1:0]  perm_d [N];
  logic [IW-1:0]  swap_d [N];
  logic [IW-1:0]  widx_q;
  logic [IW-1:0]  w_q;
  logic [IW-1:0]  j_q;
  logic [IW-1:0]  j_d;
  logic [SW-1:0]  sum_q;
  logic [SW-1:0]  min_trk_q;
  logic [SW-1:0]  min_cost_q;
  logic [SW-1:0]  total_d;
  logic [MCW-1:0] cnt_trk_q;
  logic [MCW-1:0] match_q;
  logic           busy_q;
  logic           valid_q;
  logic           has_k_d;
  int             k_idx;
  int             l_idx;
  logic [IW-1:0]  pk_d;
  logic [IW-1:0]  pl_d;

  assign W          = w_q;
  assign J          = j_q;
  assign Busy       = busy_q;
  assign Valid      = valid_q;
  assign MinCost    = min_cost_q;
  assign MatchCount = match_q;

  // Total for the current permutation: partial sum plus the last worker's cost.
  assign total_d = sum_q + SW'(Cost);

  // Lexicographic successor of perm_q. Loops use constant indices only, so every
  // lookup by k/l becomes a plain compare-and-select mux.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    has_k_d = 1'b0;
    k_idx   = 0;
    l_idx   = 0;
    pk_d    = '0;
    pl_d    = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (perm_q[i] < perm_q[i+1]) begin
        has_k_d = 1'b1;
        k_idx   = i;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (i == k_idx) pk_d = perm_q[i];
    end
    for (int i = 0; i < N; i++) begin
      if (i > k_idx && perm_q[i] > pk_d) l_idx = i;
    end
    for (int i = 0; i < N; i++) begin
      if (i == l_idx) pl_d = perm_q[i];
    end
    for (int i = 0; i < N; i++) begin
      swap_d[i] = perm_q[i];
      if (i == k_idx)      swap_d[i] = pl_d;
      else if (i == l_idx) swap_d[i] = pk_d;
    end
    // Reverse the tail after k: position i takes element N-1-(i-k-1).
    for (int i = 0; i < N; i++) begin
      perm_d[i] = swap_d[i];
      for (int m = 0; m < N; m++) begin
        if (i > k_idx && m == N + k_idx - i) perm_d[i] = swap_d[m];
      end
    end
  end

  // Job for the next worker index, presented on J in the following FETCH cycle.
  always_comb begin
    j_d = '0;
    for (int i = 0; i < N; i++) begin
      if (i == int'(widx_q) + 1) j_d = perm_q[i];
    end
  end

  // Main sequencer: enumerate, fetch, accumulate, track the minimum, publish.
  always_ff @(posedge CLK) begin
    // NOTE: all sequential state uses non-blocking assignments, so every register
    // sees the values from before the edge no matter the order of statements.
    if (RST) begin
      state_q    <= S_IDLE;
      widx_q     <= '0;
      w_q        <= '0;
      j_q        <= '0;
      sum_q      <= '0;
      min_trk_q  <= '0;
      cnt_trk_q  <= '0;
      min_cost_q <= '0;
      match_q    <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      // NOTE: the permutation array is a handful of flops, not a RAM, so it is
      // reset along with everything else.
      for (int i = 0; i < N; i++) perm_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            for (int i = 0; i < N; i++) perm_q[i] <= IW'(i);
            min_trk_q <= '1;
            cnt_trk_q <= '0;
            sum_q     <= '0;
            widx_q    <= '0;
            w_q       <= '0;
            j_q       <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Cost seen here belongs to worker widx-1; at widx=0 it is stale.
          if (widx_q != '0) sum_q <= total_d;
          if (widx_q == IW'(N - 1)) begin
            state_q <= S_LAST;
          end else begin
            widx_q <= widx_q + 1'b1;
            w_q    <= widx_q + 1'b1;
            j_q    <= j_d;
          end
        end
        S_LAST: begin
          if (total_d < min_trk_q) begin
            min_trk_q <= total_d;
            cnt_trk_q <= MCW'(1);
          end else if (total_d == min_trk_q && cnt_trk_q != '1) begin
            cnt_trk_q <= cnt_trk_q + 1'b1;
          end
          state_q <= S_NEXT;
        end
        S_NEXT: begin
          if (!has_k_d) begin
            min_cost_q <= min_trk_q;
            match_q    <= cnt_trk_q;
            valid_q    <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            for (int i = 0; i < N; i++) perm_q[i] <= perm_d[i];
            sum_q   <= '0;
            widx_q  <= '0;
            w_q     <= '0;
            j_q     <= perm_d[0];
            state_q <= S_FETCH;
          end
        end
        S_DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef JAM_BEST_PERM_EN
  logic [N*IW-1:0] best_trk_q;
  logic [N*IW-1:0] best_q;

  assign BestPerm = best_q;

  // Best-assignment tracking: capture only on strict improvement, publish at DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      best_trk_q <= '0;
      best_q     <= '0;
    end else begin
      if (state_q == S_LAST && total_d < min_trk_q) begin
        for (int i = 0; i < N; i++) best_trk_q[i*IW +: IW] <= perm_q[i];
      end
      if (state_q == S_NEXT && !has_k_d) best_q <= best_trk_q;
    end
  end
`endif

endmodule

// File: tb/tb_jam_param.sv
`timescale 1ns/1ps
// tb_jam_param: table-driven bench for jam_param. It uses three small instances
// (N=2, N=3 with a 2-bit MatchCount, N=4), and each one reads a shared cost
// table model with one-cycle latency. BestPerm checks are active only when
// JAM_BEST_PERM_EN is defined.

module tb_jam_param;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST;
  logic       start2, start3, start4;
  logic [6:0] cost2, cost3, cost4;
  logic [0:0] w2, j2;
  logic [1:0] w3, j3;
  logic [2:0] w4, j4;
  logic       busy2, busy3, busy4;
  logic       valid2, valid3, valid4;
  logic [7:0] min2;
  logic [8:0] min3;
  logic [9:0] min4;
  logic [15:0] cnt2;
  logic [1:0]  cnt3;
  logic [15:0] cnt4;
`ifdef JAM_BEST_PERM_EN
  logic [1:0]  best2;
  logic [5:0]  best3;
  logic [11:0] best4;
`endif

  logic [6:0] tbl [8][8];

  jam_param #(.N(2), .CW(7), .IW(1), .MCW(16)) u2 (
    .CLK(CLK), .RST(RST), .Start(start2), .W(w2), .J(j2), .Cost(cost2),
    .Busy(busy2), .Valid(valid2), .MinCost(min2), .MatchCount(cnt2)
`ifdef JAM_BEST_PERM_EN
    , .BestPerm(best2)
`endif
  );

  jam_param #(.N(3), .CW(7), .IW(2), .MCW(2)) u3 (
    .CLK(CLK), .RST(RST), .Start(start3), .W(w3), .J(j3), .Cost(cost3),
    .Busy(busy3), .Valid(valid3), .MinCost(min3), .MatchCount(cnt3)
`ifdef JAM_BEST_PERM_EN
    , .BestPerm(best3)
`endif
  );

  jam_param #(.N(4), .CW(7), .IW(3), .MCW(16)) u4 (
    .CLK(CLK), .RST(RST), .Start(start4), .W(w4), .J(j4), .Cost(cost4),
    .Busy(busy4), .Valid(valid4), .MinCost(min4), .MatchCount(cnt4)
`ifdef JAM_BEST_PERM_EN
    , .BestPerm(best4)
`endif
  );

  // Cost table model: registers W/J at the edge, so data appears one cycle later.
  always @(posedge CLK) begin
    cost2 <= tbl[{2'b00, w2}][{2'b00, j2}];
    cost3 <= tbl[{1'b0, w3}][{1'b0, j3}];
    cost4 <= tbl[w4][j4];
  end

  typedef logic [3:0][3:0][6:0] cmat_t;

  typedef struct {
    string       name;
    int          n;
    cmat_t       c;
    logic [9:0]  emin;
    logic [15:0] ecnt;
    logic [11:0] ebest;
    int          eedges;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_n    = 0;

  logic        cur_valid, cur_busy;
  logic [9:0]  cur_min;
  logic [15:0] cur_cnt;
  logic [11:0] cur_best;

  always_comb begin
    cur_valid = 1'b0;
    cur_busy  = 1'b0;
    cur_min   = '0;
    cur_cnt   = '0;
    cur_best  = '0;
    case (cur_n)
      2: begin
        cur_valid = valid2; cur_busy = busy2;
        cur_min = {2'b00, min2}; cur_cnt = cnt2;
`ifdef JAM_BEST_PERM_EN
        cur_best = {10'b0, best2};
`endif
      end
      3: begin
        cur_valid = valid3; cur_busy = busy3;
        cur_min = {1'b0, min3}; cur_cnt = {14'b0, cnt3};
`ifdef JAM_BEST_PERM_EN
        cur_best = {6'b0, best3};
`endif
      end
      4: begin
        cur_valid = valid4; cur_busy = busy4;
        cur_min = min4; cur_cnt = cnt4;
`ifdef JAM_BEST_PERM_EN
        cur_best = best4;
`endif
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input int n, input logic val);
    case (n)
      2: start2 = val;
      3: start3 = val;
      4: start4 = val;
      default: ;
    endcase
  endtask

  function automatic cmat_t uni(input logic [6:0] val);
    cmat_t r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[i][j] = val;
    return r;
  endfunction

  task automatic load_tbl(input cmat_t c);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        tbl[i][j] = (i < 4 && j < 4) ? c[i][j] : 7'd0;
  endtask

  // One full run: pulse Start, time Valid from the Start edge, check results.
  task automatic run_vec(input vec_t v);
    int edges;
    bit got;
    load_tbl(v.c);
    cur_n = v.n;
    @(negedge CLK); set_start(v.n, 1'b1);
    @(posedge CLK); #1;
    check({v.name, "_busy_on_start"}, 32'(cur_busy), 32'd1);
    @(negedge CLK); set_start(v.n, 1'b0);
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 2000) begin
      @(posedge CLK); edges++; #1;
      if (cur_valid) got = 1'b1;
    end
    check({v.name, "_valid_edge"}, 32'(edges), 32'(v.eedges));
    check({v.name, "_min_cost"}, 32'(cur_min), 32'(v.emin));
    check({v.name, "_match_count"}, 32'(cur_cnt), 32'(v.ecnt));
`ifdef JAM_BEST_PERM_EN
    check({v.name, "_best_perm"}, 32'(cur_best), 32'(v.ebest));
`endif
    @(posedge CLK); #1;
    check({v.name, "_valid_one_cycle"}, 32'(cur_valid), 32'd0);
    check({v.name, "_busy_after_done"}, 32'(cur_busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    vec_t v;
    vec_t diag4;
    int nval, vedge, extra;

    // Vector table: expected totals and counts derived by hand.
    v.name = "n2_basic"; v.n = 2; v.c = uni(7'd0);
    v.c[0][0] = 7'd1; v.c[0][1] = 7'd2; v.c[1][0] = 7'd2; v.c[1][1] = 7'd1;
    v.emin = 10'd2; v.ecnt = 16'd1; v.ebest = 12'h002; v.eedges = 8; vecs.push_back(v);

    v.name = "n2_swap"; v.n = 2; v.c = uni(7'd0);
    v.c[0][0] = 7'd3; v.c[0][1] = 7'd1; v.c[1][0] = 7'd1; v.c[1][1] = 7'd3;
    v.emin = 10'd2; v.ecnt = 16'd1; v.ebest = 12'h001; v.eedges = 8; vecs.push_back(v);

    v.name = "n2_max"; v.n = 2; v.c = uni(7'd127);
    v.emin = 10'd254; v.ecnt = 16'd2; v.ebest = 12'h002; v.eedges = 8; vecs.push_back(v);

    v.name = "n3_cyclic"; v.n = 3; v.c = uni(7'd0);
    v.c[0][0] = 7'd3; v.c[0][1] = 7'd1; v.c[0][2] = 7'd2;
    v.c[1][0] = 7'd2; v.c[1][1] = 7'd3; v.c[1][2] = 7'd1;
    v.c[2][0] = 7'd1; v.c[2][1] = 7'd2; v.c[2][2] = 7'd3;
    v.emin = 10'd3; v.ecnt = 16'd1; v.ebest = 12'h009; v.eedges = 30; vecs.push_back(v);

    v.name = "n3_tie"; v.n = 3; v.c = uni(7'd1);
    v.c[0][2] = 7'd5; v.c[1][2] = 7'd5; v.c[2][0] = 7'd5; v.c[2][1] = 7'd5;
    v.emin = 10'd3; v.ecnt = 16'd2; v.ebest = 12'h024; v.eedges = 30; vecs.push_back(v);

    v.name = "n3_saturate"; v.n = 3; v.c = uni(7'd5);
    v.emin = 10'd15; v.ecnt = 16'd3; v.ebest = 12'h024; v.eedges = 30; vecs.push_back(v);

    v.name = "n4_diag"; v.n = 4; v.c = uni(7'd100);
    for (int i = 0; i < 4; i++) v.c[i][i] = 7'd0;
    v.emin = 10'd0; v.ecnt = 16'd1; v.ebest = 12'h688; v.eedges = 144; vecs.push_back(v);
    diag4 = v;

    v.name = "n4_anti"; v.n = 4; v.c = uni(7'd9);
    for (int i = 0; i < 4; i++) v.c[i][3-i] = 7'd0;
    v.emin = 10'd0; v.ecnt = 16'd1; v.ebest = 12'h053; v.eedges = 144; vecs.push_back(v);

    v.name = "n4_max"; v.n = 4; v.c = uni(7'd127);
    v.emin = 10'd508; v.ecnt = 16'd24; v.ebest = 12'h688; v.eedges = 144; vecs.push_back(v);

    v.name = "n4_all5"; v.n = 4; v.c = uni(7'd5);
    v.emin = 10'd20; v.ecnt = 16'd24; v.ebest = 12'h688; v.eedges = 144; vecs.push_back(v);

    // Reset state.
    RST = 1'b1; start2 = 1'b0; start3 = 1'b0; start4 = 1'b0;
    load_tbl(uni(7'd0));
    repeat (3) @(posedge CLK);
    @(negedge CLK); RST = 1'b0;
    check("reset_u4_wj", 32'({w4, j4}), 32'd0);
    check("reset_u4_flags", 32'({busy4, valid4}), 32'd0);
    check("reset_u4_min", 32'(min4), 32'd0);
    check("reset_u4_cnt", 32'(cnt4), 32'd0);
    check("reset_u2_all", 32'({w2, j2, busy2, valid2, min2, cnt2}), 32'd0);
    check("reset_u3_all", 32'({w3, j3, busy3, valid3, min3, cnt3}), 32'd0);
`ifdef JAM_BEST_PERM_EN
    check("reset_best", 32'({best2, best3, best4}), 32'd0);
`endif

    foreach (vecs[i]) run_vec(vecs[i]);

    // Start held high while busy and through the Valid cycle: one run only.
    cur_n = 2;
    load_tbl(vecs[0].c);
    @(negedge CLK); start2 = 1'b1;
    @(posedge CLK);
    nval = 0; vedge = -1;
    for (int n = 1; n <= 9; n++) begin
      @(posedge CLK); #1;
      if (valid2) begin
        nval++;
        if (vedge < 0) vedge = n;
      end
      if (n == 1) check("hold_w_j_edge1", 32'({w2, j2}), 32'b11);
      if (n == 2) check("hold_w_in_last", 32'(w2), 32'd1);
      if (n == 4) check("hold_w_j_perm2_w0", 32'({w2, j2}), 32'b01);
      if (n == 5) check("hold_w_j_perm2_w1", 32'({w2, j2}), 32'b10);
      if (n == 9) check("hold_busy_after_done", 32'(busy2), 32'd0);
    end
    @(negedge CLK); start2 = 1'b0;
    extra = 0;
    repeat (20) begin
      @(posedge CLK); #1;
      if (valid2 || busy2) extra++;
    end
    check("hold_valid_count", 32'(nval), 32'd1);
    check("hold_valid_edge", 32'(vedge), 32'd8);
    check("hold_no_restart", 32'(extra), 32'd0);
    check("hold_min_cost", 32'(min2), 32'd2);

    // Mid-run reset with Start also high during reset, then a clean rerun.
    cur_n = 4;
    load_tbl(diag4.c);
    @(negedge CLK); start4 = 1'b1;
    @(negedge CLK); start4 = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK); RST = 1'b1; start4 = 1'b1;
    @(posedge CLK); #1;
    check("rst_mid_wj", 32'({w4, j4}), 32'd0);
    check("rst_mid_flags", 32'({busy4, valid4}), 32'd0);
    check("rst_mid_min", 32'(min4), 32'd0);
    check("rst_mid_cnt", 32'(cnt4), 32'd0);
`ifdef JAM_BEST_PERM_EN
    check("rst_mid_best", 32'(best4), 32'd0);
`endif
    @(negedge CLK); RST = 1'b0; start4 = 1'b0;
    extra = 0;
    repeat (200) begin
      @(posedge CLK); #1;
      if (valid4 || busy4) extra++;
    end
    check("rst_mid_no_valid", 32'(extra), 32'd0);
    diag4.name = "n4_diag_rerun";
    run_vec(diag4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
